// File: rtl/mb_audio_pcm.sv
// mb_audio_pcm: Mockingboard audio back end.
// Each PSG sum and the Apple speaker level is averaged over a window of
// 2^LOG2_DECIM clocks. The centred speaker duty cycle is mixed into both
// channels, DC is removed with a leaky first-order high-pass filter, and the
// result is emitted as saturated 16-bit signed stereo PCM.
//
// Ports:
//   CLK_14M       in   1   system clock, 14.318 MHz
//   I_RESET       in   1   synchronous reset, active high
//   I_AUDIO_L/R   in   10  unsigned PSG sums, 0..765
//   I_SPEAKER     in   1   Apple speaker level
//   I_MB_ENA      in   1   card enable; 0 forces the PSG inputs to 0
//   O_PCM_L/R     out  16  signed PCM, held between strobes
//   O_SAMPLE_STB  out  1   one-cycle pulse marking new O_PCM_L/R
//
// state | meaning
// IDLE  | accumulating the current window
// PREP  | build x from the window average plus the centred speaker term
// DC    | high-pass update of y; output registers load on exit
// OUT   | strobe cycle, new PCM on the outputs
module mb_audio_pcm #(
    parameter int LOG2_DECIM = 8,
    parameter int SPK_SHIFT  = 5,
    parameter int DC_SHIFT   = 10
) (
    input  logic               CLK_14M,
    input  logic               I_RESET,
    input  logic [9:0]         I_AUDIO_L,
    input  logic [9:0]         I_AUDIO_R,
    input  logic               I_SPEAKER,
    input  logic               I_MB_ENA,
    output logic signed [15:0] O_PCM_L,
    output logic signed [15:0] O_PCM_R,
    output logic               O_SAMPLE_STB
);

    localparam int ACC_W  = 10 + LOG2_DECIM;
    localparam int ONES_W = LOG2_DECIM + 1;
    localparam logic [16:0] HALF_N = 17'(2 ** (LOG2_DECIM - 1));
    localparam logic [LOG2_DECIM-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {IDLE, PREP, DC, OUT} state_t;

    state_t state, state_nxt;
    logic   load_x, load_y, stb_nxt;

    logic [LOG2_DECIM-1:0] cnt;
    logic [ACC_W-1:0]      acc_l, acc_r, sum_l, sum_r;
    logic [ONES_W-1:0]     spk_ones, ones_sum, ones;
    logic [9:0]            in_l, in_r, avg_l, avg_r;
    logic                  win_end;

    logic [16:0]           spk_u, x_l_nxt, x_r_nxt;
    logic signed [16:0]    x_l, x_r, x_prev_l, x_prev_r, d_l, d_r;
    logic signed [25:0]    y_l, y_r, y_next_l, y_next_r, dext_l, dext_r;

    function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
        if (v > 18'sd32767)
            return 16'sd32767;
        else if (v < -18'sd32768)
            return -16'sd32768;
        else
            return v[15:0];
    endfunction

    assign in_l     = I_MB_ENA ? I_AUDIO_L : '0;
    assign in_r     = I_MB_ENA ? I_AUDIO_R : '0;
    assign sum_l    = acc_l + ACC_W'(in_l);
    assign sum_r    = acc_r + ACC_W'(in_r);
    assign ones_sum = spk_ones + ONES_W'(I_SPEAKER);
    assign win_end  = (cnt == CNT_LAST);

    // Unsigned 17-bit arithmetic wraps to the right two's-complement value.
    assign spk_u   = (17'(ones) - HALF_N) << SPK_SHIFT;
    assign x_l_nxt = 17'({avg_l, 5'b0}) + spk_u;
    assign x_r_nxt = 17'({avg_r, 5'b0}) + spk_u;

    assign d_l      = x_l - x_prev_l;
    assign d_r      = x_r - x_prev_r;
    assign dext_l   = {{9{d_l[16]}}, d_l};
    assign dext_r   = {{9{d_r[16]}}, d_r};
    assign y_next_l = y_l + (dext_l <<< 8) - (y_l >>> DC_SHIFT);
    assign y_next_r = y_r + (dext_r <<< 8) - (y_r >>> DC_SHIFT);

    always_comb begin
        state_nxt = state;
        load_x    = 1'b0;
        load_y    = 1'b0;
        stb_nxt   = 1'b0;
        case (state)
            IDLE: if (win_end) state_nxt = PREP;
            PREP: begin
                load_x    = 1'b1;
                state_nxt = DC;
            end
            DC: begin
                load_y    = 1'b1;
                stb_nxt   = 1'b1;
                state_nxt = OUT;
            end
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_14M) begin
        if (I_RESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge CLK_14M) begin
        if (I_RESET) begin
            cnt          <= '0;
            acc_l        <= '0;
            acc_r        <= '0;
            spk_ones     <= '0;
            avg_l        <= '0;
            avg_r        <= '0;
            ones         <= '0;
            x_l          <= '0;
            x_r          <= '0;
            x_prev_l     <= '0;
            x_prev_r     <= '0;
            y_l          <= '0;
            y_r          <= '0;
            O_PCM_L      <= '0;
            O_PCM_R      <= '0;
            O_SAMPLE_STB <= 1'b0;
        end else begin
            cnt          <= cnt + 1'b1;
            O_SAMPLE_STB <= stb_nxt;
            // The closing clock's input goes into the average, not the next window.
            if (win_end) begin
                avg_l    <= sum_l[ACC_W-1:LOG2_DECIM];
                avg_r    <= sum_r[ACC_W-1:LOG2_DECIM];
                ones     <= ones_sum;
                acc_l    <= '0;
                acc_r    <= '0;
                spk_ones <= '0;
            end else begin
                acc_l    <= sum_l;
                acc_r    <= sum_r;
                spk_ones <= ones_sum;
            end
            if (load_x) begin
                x_l <= $signed(x_l_nxt);
                x_r <= $signed(x_r_nxt);
            end
            if (load_y) begin
                y_l      <= y_next_l;
                y_r      <= y_next_r;
                x_prev_l <= x_l;
                x_prev_r <= x_r;
                O_PCM_L  <= sat16(y_next_l[25:8]);
                O_PCM_R  <= sat16(y_next_r[25:8]);
            end
        end
    end

endmodule

// File: tb/tb_mb_audio_pcm.sv
module tb_mb_audio_pcm;

    localparam int N = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [9:0] aud_l = '0, aud_r = '0;
    logic spk = 1'b0, ena = 1'b1;
    logic signed [15:0] pcm_l, pcm_r;
    logic stb;

    always #35 clk = ~clk;

    mb_audio_pcm dut (
        .CLK_14M(clk), .I_RESET(rst), .I_AUDIO_L(aud_l), .I_AUDIO_R(aud_r),
        .I_SPEAKER(spk), .I_MB_ENA(ena), .O_PCM_L(pcm_l), .O_PCM_R(pcm_r),
        .O_SAMPLE_STB(stb)
    );

    int n_checks = 0, n_err = 0;

    // reference model state (one entry per clock edge)
    int     e_abs = 0, rel = -1, win_pos = 0;
    longint sum_l = 0, sum_r = 0, ones = 0;
    longint y_l = 0, y_r = 0, xp_l = 0, xp_r = 0;
    bit     pend = 0;
    int     pend_e = 0;
    longint pend_l = 0, pend_r = 0;
    bit     exp_valid = 0, exp_stb = 0;
    longint exp_l = 0, exp_r = 0;

    // strobe observations
    bit     seen = 0;
    int     stb_clk = 0, last_stb_e = -1, n_stb_phase = 0;
    longint stb_l = 0, stb_r = 0;

    // stimulus configuration: spk_mode 0=low 1=high 2=toggle 3=random
    logic [9:0] cfg_l = '0, cfg_r = '0;
    int  cfg_spk = 0;
    logic cfg_ena = 1'b1;
    bit  cfg_rand = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        n_checks++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic longint sat(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Window-level model: average, centred speaker duty, high-pass, saturate.
    task automatic model_edge(input logic r, input logic [9:0] al, input logic [9:0] ar,
                              input logic sp, input logic en);
        longint x_l, x_r, spk_term;
        e_abs++;
        exp_valid = 1;
        exp_stb = 0;
        if (r) begin
            rel = -1; win_pos = 0; sum_l = 0; sum_r = 0; ones = 0;
            y_l = 0; y_r = 0; xp_l = 0; xp_r = 0; pend = 0;
            exp_l = 0; exp_r = 0; last_stb_e = -1;
            return;
        end
        rel++;
        if (en) begin
            sum_l += al;
            sum_r += ar;
        end
        ones += sp;
        if (win_pos == N - 1) begin
            spk_term = (ones - N / 2) * 32;
            x_l = (sum_l / N) * 32 + spk_term;
            x_r = (sum_r / N) * 32 + spk_term;
            y_l = y_l + (x_l - xp_l) * 256 - (y_l >>> 10);
            y_r = y_r + (x_r - xp_r) * 256 - (y_r >>> 10);
            xp_l = x_l; xp_r = x_r;
            pend = 1; pend_e = e_abs + 2;
            pend_l = sat(y_l >>> 8); pend_r = sat(y_r >>> 8);
            win_pos = 0; sum_l = 0; sum_r = 0; ones = 0;
        end else begin
            win_pos++;
        end
        if (pend && pend_e == e_abs) begin
            exp_stb = 1; exp_l = pend_l; exp_r = pend_r; pend = 0;
        end
    endtask

    // Compare the outputs of the previous edge, then drive the next edge.
    task automatic step(input logic r, input logic [9:0] al, input logic [9:0] ar,
                        input logic sp, input logic en);
        @(negedge clk);
        if (exp_valid) begin
            chk("stb", longint'(stb), longint'(exp_stb));
            chk("pcm_l", longint'(pcm_l), exp_l);
            chk("pcm_r", longint'(pcm_r), exp_r);
            if (stb) begin
                seen = 1; stb_clk = rel + 1; n_stb_phase++;
                stb_l = pcm_l; stb_r = pcm_r;
                if (last_stb_e >= 0) chk("stb_period", e_abs - last_stb_e, N);
                last_stb_e = e_abs;
            end
        end
        rst = r; aud_l = al; aud_r = ar; spk = sp; ena = en;
        model_edge(r, al, ar, sp, en);
    endtask

    task automatic tick();
        logic [9:0] al, ar;
        logic sp, en;
        al = cfg_rand ? 10'($urandom_range(0, 1023)) : cfg_l;
        ar = cfg_rand ? 10'($urandom_range(0, 1023)) : cfg_r;
        case (cfg_spk)
            0: sp = 1'b0;
            1: sp = 1'b1;
            2: sp = 1'(e_abs % 2);
            default: sp = 1'($urandom_range(0, 1));
        endcase
        en = cfg_rand ? ($urandom_range(0, 7) != 0) : cfg_ena;
        step(1'b0, al, ar, sp, en);
    endtask

    task automatic do_reset();
        step(1'b1, cfg_l, cfg_r, 1'b0, cfg_ena);
        step(1'b1, cfg_l, cfg_r, 1'b0, cfg_ena);
        n_stb_phase = 0;
    endtask

    task automatic wait_stb(input string name);
        int i;
        seen = 0;
        i = 0;
        while (!seen && i < 600) begin
            tick();
            i++;
        end
        if (!seen) begin
            n_checks++; n_err++;
            $display("FAIL %s: no strobe within 600 clocks, expected one", name);
        end
    endtask

    initial begin
        // reset with everything at zero
        cfg_l = 0; cfg_r = 0; cfg_spk = 0; cfg_ena = 1; cfg_rand = 0;
        do_reset();
        chk("reset_stb", longint'(stb), 0);
        chk("reset_pcm_l", longint'(pcm_l), 0);
        wait_stb("zero_first");
        chk("zero_first_clk", stb_clk, 258);
        chk("zero_first_l", stb_l, -4096);
        chk("zero_first_r", stb_r, -4096);
        wait_stb("zero_second");
        chk("zero_second_clk", stb_clk, 514);
        chk("zero_second_l", stb_l, -4092);

        // full-scale PSG, speaker toggling
        cfg_l = 765; cfg_r = 765; cfg_spk = 2;
        do_reset();
        wait_stb("full_first");
        chk("full_first_l", stb_l, 24480);
        chk("full_first_r", stb_r, 24480);
        wait_stb("full_second");
        chk("full_second_l", stb_l, 24456);
        chk("full_second_r", stb_r, 24456);

        // independent channels, speaker held high
        cfg_l = 765; cfg_r = 0; cfg_spk = 1;
        do_reset();
        wait_stb("indep");
        chk("indep_l", stb_l, 28576);
        chk("indep_r", stb_r, 4096);

        // card disabled
        cfg_l = 765; cfg_r = 765; cfg_spk = 2; cfg_ena = 0;
        do_reset();
        wait_stb("dis_first");
        chk("dis_first_l", stb_l, 0);
        wait_stb("dis_second");
        chk("dis_second_r", stb_r, 0);

        // reset pulse mid-window, then mid-FSM
        cfg_ena = 1;
        do_reset();
        while (rel < 99) tick();
        step(1'b1, cfg_l, cfg_r, 1'b0, cfg_ena);
        wait_stb("rst_mid");
        chk("rst_mid_clk", stb_clk, 258);
        chk("rst_mid_l", stb_l, 24480);
        while (rel < 511) tick();
        step(1'b1, cfg_l, cfg_r, 1'b0, cfg_ena);
        tick();
        chk("rst_fsm_pcm_l", longint'(pcm_l), 0);
        chk("rst_fsm_stb", longint'(stb), 0);
        wait_stb("rst_fsm");
        chk("rst_fsm_clk", stb_clk, 258);
        chk("rst_fsm_r", stb_r, 24480);

        // over-range input saturates
        cfg_l = 1023; cfg_r = 0; cfg_spk = 1;
        do_reset();
        wait_stb("sat");
        chk("sat_l", stb_l, 32767);
        chk("sat_r", stb_r, 4096);

        // long randomized run, strobe shape and period checked every cycle
        cfg_rand = 1; cfg_spk = 3;
        do_reset();
        for (int i = 0; i < 120 * N; i++) tick();
        tick();
        chk("rand_strobe_count", n_stb_phase, 119);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
